// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel registered stream multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width needed to index n items, never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_nto1_arb_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int SELW = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SELW-1:0] ptr,
    input  logic            advance,
    output logic [SELW-1:0] gnt,
    output logic            gnt_v
);

    int idx;
    logic found;

    // First requesting channel in the order ptr+1, ptr+2, ..., ptr.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt   = SELW'(idx);
            end
        end
    end

    // advance qualifies the grant so the arbiter is silent when not in use.
    assign gnt_v = advance & (|req);

endmodule

// File: rtl/mux_nto1_arb.sv
// N-channel registered stream multiplexer with fixed or round-robin selection.
module mux_nto1_arb
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int SELW = clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [SELW-1:0]   s,
    input  logic [N_CH*W-1:0] d,
    input  logic [N_CH-1:0]   d_valid,
    output logic [N_CH-1:0]   d_ready,
    output logic [W-1:0]      z,
    output logic              z_valid,
    input  logic              z_ready,
    output logic [SELW-1:0]   z_ch
);

    logic [W-1:0]    d_ch [N_CH];
    logic [W-1:0]    z_reg;
    logic            z_valid_reg;
    logic [SELW-1:0] z_ch_reg;
    logic [SELW-1:0] ptr_reg;

    logic [SELW-1:0] rr_gnt;
    logic            rr_gnt_v;
    logic            fix_gnt_v;
    logic [SELW-1:0] gnt;
    logic            gnt_v;
    logic            load_ok;
    logic            xfer;

    // The output register can take a word when empty or draining this cycle.
    assign load_ok = en & (~z_valid_reg | z_ready);

    rr_arbiter #(
        .N_CH (N_CH),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req     (d_valid),
        .ptr     (ptr_reg),
        .advance (mode == MODE_RR),
        .gnt     (rr_gnt),
        .gnt_v   (rr_gnt_v)
    );

    // Fixed-mode valid: a select beyond the last channel never grants.
    always_comb begin
        fix_gnt_v = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (s == SELW'(i)) begin
                fix_gnt_v = d_valid[i];
            end
        end
    end

    assign gnt   = (mode == MODE_RR) ? rr_gnt   : s;
    assign gnt_v = (mode == MODE_RR) ? rr_gnt_v : fix_gnt_v;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign d_ch[gi]    = d[gi*W +: W];
            assign d_ready[gi] = load_ok & gnt_v & (gnt == SELW'(gi));
        end
    endgenerate

    assign xfer = |(d_valid & d_ready);

    // Output word, source index and rr pointer; a load may replace a draining word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_reg       <= '0;
            z_valid_reg <= 1'b0;
            z_ch_reg    <= '0;
            ptr_reg     <= SELW'(N_CH - 1);
        end else if (xfer) begin
            z_reg       <= d_ch[gnt];
            z_ch_reg    <= gnt;
            z_valid_reg <= 1'b1;
            ptr_reg     <= gnt;
        end else if (z_valid_reg && z_ready) begin
            z_valid_reg <= 1'b0;
        end
    end

    assign z       = z_reg;
    assign z_valid = z_valid_reg;
    assign z_ch    = z_ch_reg;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Self-checking bench for mux_nto1_arb: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_mux_nto1_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          mode;
    logic [1:0]    s;
    logic [N*W-1:0] d;
    logic [N-1:0]  d_valid;
    logic [N-1:0]  d_ready;
    logic [W-1:0]  z;
    logic          z_valid;
    logic          z_ready;
    logic [1:0]    z_ch;

    int n_chk;
    int n_pass;

    // model state
    int       m_ptr;
    logic [7:0] m_z;
    logic     m_zv;
    int       m_zch;

    mux_nto1_arb #(.N_CH(N), .W(W), .SELW(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .s       (s),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .z       (z),
        .z_valid (z_valid),
        .z_ready (z_ready),
        .z_ch    (z_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Grant decision straight from the selection rules.
    function automatic void ref_grant(output int g, output bit gv);
        g  = 0;
        gv = 0;
        if (mode == 1'b0) begin
            g  = int'(s);
            gv = (g < N) ? d_valid[g] : 1'b0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!gv && d_valid[c]) begin
                    g  = c;
                    gv = 1;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] ref_ready();
        int  g;
        bit  gv;
        bit  lok;
        ref_grant(g, gv);
        lok = en && (!m_zv || z_ready);
        return (lok && gv) ? (N'(1) << g) : '0;
    endfunction

    task automatic model_reset();
        m_ptr = N - 1;
        m_z   = '0;
        m_zv  = 1'b0;
        m_zch = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cyc();
        int g;
        bit gv;
        logic [N-1:0] r;
        #1;
        r = ref_ready();
        check_val("d_ready", 32'(d_ready), 32'(r));
        check_val("z_valid", 32'(z_valid), 32'(m_zv));
        check_val("z", 32'(z), 32'(m_z));
        check_val("z_ch", 32'(z_ch), 32'(m_zch));
        $display("cyc t=%0t mode=%0d s=%0d en=%0d dv=%b zr=%0d | z=%h zv=%0d zch=%0d rdy=%b",
                 $time, mode, s, en, d_valid, z_ready, z, z_valid, z_ch, d_ready);
        @(posedge clk);
        ref_grant(g, gv);
        if (r != '0) begin
            m_z   = d[g*W +: W];
            m_zch = g;
            m_zv  = 1'b1;
            m_ptr = g;
        end else if (m_zv && z_ready) begin
            m_zv = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_rr [5];
        int sparse [4];
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        mode    = 1'b0;
        s       = '0;
        d       = '0;
        d_valid = '0;
        z_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_z", 32'(z), 32'h0);
        check_val("rst_zv", 32'(z_valid), 32'h0);
        check_val("rst_zch", 32'(z_ch), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // round-robin, all valid
        mode = 1'b1; en = 1'b1; d_valid = 4'b1111; z_ready = 1'b1;
        d = 32'h44332211;
        exp_rr[0] = 8'h11; exp_rr[1] = 8'h22; exp_rr[2] = 8'h33; exp_rr[3] = 8'h44; exp_rr[4] = 8'h11;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_val("rr_z", 32'(z), 32'(exp_rr[i]));
            check_val("rr_zch", 32'(z_ch), 32'(i % N));
            check_val("rr_zv", 32'(z_valid), 32'h1);
        end

        // fixed select
        mode = 1'b0; s = 2'd2; d_valid = 4'b0100; d = 32'h00A50000;
        #1 check_val("fix_rdy", 32'(d_ready), 32'h4);
        cyc();
        check_val("fix_z", 32'(z), 32'hA5);
        check_val("fix_zch", 32'(z_ch), 32'h2);
        s = 2'd1; d_valid = 4'b0000;
        #1 check_val("fix_rdy0", 32'(d_ready), 32'h0);
        cyc();
        check_val("fix_drain", 32'(z_valid), 32'h0);

        // back-pressure: load 22 from channel 1, then stall
        mode = 1'b1; d = 32'h44332211; d_valid = 4'b0010;
        cyc();
        check_val("bp_z", 32'(z), 32'h22);
        z_ready = 1'b0; d_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("bp_hold", 32'(z), 32'h22);
            check_val("bp_rdy", 32'(d_ready), 32'h0);
        end
        z_ready = 1'b1;
        cyc();
        check_val("bp_next", 32'(z_ch), 32'h2);

        // enable low drains without loading
        en = 1'b0;
        cyc();
        check_val("en_drain", 32'(z_valid), 32'h0);
        en = 1'b1;
        cyc();
        check_val("en_resume", 32'(z_ch), 32'h3);

        // sparse round-robin from ptr=3
        d_valid = 4'b1010;
        sparse[0] = 1; sparse[1] = 3; sparse[2] = 1; sparse[3] = 3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_val("sparse", 32'(z_ch), 32'(sparse[i]));
        end
        d_valid = 4'b1011;
        cyc();
        check_val("sparse_add0", 32'(z_ch), 32'h0);

        // asynchronous reset mid-cycle while holding a word
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_zv", 32'(z_valid), 32'h0);
        check_val("arst_z", 32'(z), 32'h0);
        check_val("arst_zch", 32'(z_ch), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        d_valid = 4'b1111;
        cyc();
        check_val("arst_first", 32'(z_ch), 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            mode    = 1'($urandom_range(0, 1));
            s       = 2'($urandom_range(0, 3));
            en      = ($urandom_range(0, 7) != 0);
            d_valid = 4'($urandom);
            d       = 32'($urandom);
            z_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
